// File: rtl/dp_ram_be_if.sv
// One RAM port: request strobe, byte write enables, address, write data and the
// registered read return. The requester uses master, the RAM uses slave.
interface dp_ram_be_if #(
    parameter int data_width = 32,
    parameter int addr_width = 10,
    parameter int byte_width = 8
);
    localparam int nb = data_width / byte_width;

    logic                  en;
    logic [nb-1:0]         we;
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] wdata;
    logic [data_width-1:0] rdata;
    logic                  rvalid;

    modport master (output en, we, addr, wdata, input rdata, rvalid);
    modport slave  (input en, we, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/dp_ram_be.sv
// True dual-port byte-enabled RAM on one clock with selectable read-during-write
// behaviour, 1- or 2-cycle read pipeline and same-address dual-write detection.
module dp_ram_be #(
    parameter int data_width = 32,
    parameter int addr_width = 10,
    parameter int byte_width = 8,
    parameter int rd_latency = 1,
    parameter int write_mode = 0
) (
    input  logic       clk,
    input  logic       rst,
    dp_ram_be_if.slave a,
    dp_ram_be_if.slave b,
    output logic       collision
);
    localparam int nb    = data_width / byte_width;
    localparam int depth = 2 ** addr_width;

    logic [data_width-1:0] mem [depth];

    logic                  en_s    [2];
    logic [nb-1:0]         we_s    [2];
    logic [addr_width-1:0] addr_s  [2];
    logic [data_width-1:0] wdata_s [2];
    logic [data_width-1:0] old_s   [2];
    logic [data_width-1:0] ret_s   [2];
    logic                  ret_v_s [2];
    logic                  coll_s;

    logic                  v1_r [2];
    logic [data_width-1:0] d1_r [2];
    logic                  v2_r [2];
    logic [data_width-1:0] d2_r [2];

    // Index 0 is port A, index 1 is port B, so both ports share one code path.
    assign en_s[0]    = a.en;
    assign we_s[0]    = a.we;
    assign addr_s[0]  = a.addr;
    assign wdata_s[0] = a.wdata;
    assign en_s[1]    = b.en;
    assign we_s[1]    = b.we;
    assign addr_s[1]  = b.addr;
    assign wdata_s[1] = b.wdata;

    // Return word and valid per port, plus same-address dual-write detection
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            old_s[p] = mem[addr_s[p]];
            ret_s[p] = old_s[p];
            for (int i = 0; i < nb; i++) begin
                if (write_mode == 32'sd1 && we_s[p][i]) begin
                    ret_s[p][i*byte_width +: byte_width] = wdata_s[p][i*byte_width +: byte_width];
                end else begin
                    ret_s[p][i*byte_width +: byte_width] = old_s[p][i*byte_width +: byte_width];
                end
            end
            if (write_mode == 32'sd2 && (|we_s[p])) begin
                ret_v_s[p] = 1'b0;
            end else begin
                ret_v_s[p] = en_s[p];
            end
        end
        coll_s = en_s[0] && en_s[1] && (|we_s[0]) && (|we_s[1]) && (addr_s[0] == addr_s[1]);
    end

    // Byte-lane writes; A is applied last so it owns lanes both ports enable
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < nb; i++) begin
                if (en_s[1] && we_s[1][i]) begin
                    mem[addr_s[1]][i*byte_width +: byte_width] <= wdata_s[1][i*byte_width +: byte_width];
                end
                if (en_s[0] && we_s[0][i]) begin
                    mem[addr_s[0]][i*byte_width +: byte_width] <= wdata_s[0][i*byte_width +: byte_width];
                end
            end
        end
    end

    // Read pipeline; data registers load only with a valid so rdata holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                v1_r[p] <= 1'b0;
                d1_r[p] <= '0;
                v2_r[p] <= 1'b0;
                d2_r[p] <= '0;
            end
            collision <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                v1_r[p] <= ret_v_s[p];
                if (ret_v_s[p]) begin
                    d1_r[p] <= ret_s[p];
                end
                v2_r[p] <= v1_r[p];
                if (v1_r[p]) begin
                    d2_r[p] <= d1_r[p];
                end
            end
            collision <= coll_s;
        end
    end

    assign a.rdata  = (rd_latency == 32'sd2) ? d2_r[0] : d1_r[0];
    assign a.rvalid = (rd_latency == 32'sd2) ? v2_r[0] : v1_r[0];
    assign b.rdata  = (rd_latency == 32'sd2) ? d2_r[1] : d1_r[1];
    assign b.rvalid = (rd_latency == 32'sd2) ? v2_r[1] : v1_r[1];
endmodule

// File: tb/tb_dp_ram_be.sv
// Drives identical traffic into three RAMs (read-first/lat1, write-first/lat2,
// no-change/lat1); expectations are queued at issue time and popped by a monitor.
module tb_dp_ram_be;
    localparam int MODES [3] = '{0, 1, 2};
    localparam int LATS  [3] = '{1, 2, 1};

    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_en = 1'b0, b_en = 1'b0;
    logic [3:0]  a_we = 4'h0, b_we = 4'h0;
    logic [9:0]  a_addr = 10'h0, b_addr = 10'h0;
    logic [31:0] a_wdata = 32'h0, b_wdata = 32'h0;

    logic        rv [6];
    logic [31:0] rd [6];
    logic        cl [3];

    exp_t q  [6][$];
    exp_t pq [6][$];
    int   cq [3][$];
    logic [31:0] mdl [int];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : gi
        dp_ram_be_if #(.data_width(32), .addr_width(10), .byte_width(8)) a_if ();
        dp_ram_be_if #(.data_width(32), .addr_width(10), .byte_width(8)) b_if ();
        logic coll;

        assign a_if.en    = a_en;
        assign a_if.we    = a_we;
        assign a_if.addr  = a_addr;
        assign a_if.wdata = a_wdata;
        assign b_if.en    = b_en;
        assign b_if.we    = b_we;
        assign b_if.addr  = b_addr;
        assign b_if.wdata = b_wdata;

        dp_ram_be #(
            .data_width(32), .addr_width(10), .byte_width(8),
            .rd_latency(LATS[g]), .write_mode(MODES[g])
        ) dut (
            .clk(clk), .rst(rst), .a(a_if), .b(b_if), .collision(coll)
        );

        assign rv[2*g]   = a_if.rvalid;
        assign rd[2*g]   = a_if.rdata;
        assign rv[2*g+1] = b_if.rvalid;
        assign rd[2*g+1] = b_if.rdata;
        assign cl[g]     = coll;
    end

    // Queue the expected return of one port for every instance
    task automatic push_port(input int p, input int c, input bit en, input logic [3:0] we,
                             input int addr, input logic [31:0] wd, input logic [31:0] x);
        logic [31:0] old, mrg;
        bit known;
        int s;
        if (en) begin
            known = mdl.exists(addr);
            old   = known ? mdl[addr] : 32'h0;
            mrg   = old;
            for (int i = 0; i < 4; i++) if (we[i]) mrg[8*i +: 8] = wd[8*i +: 8];
            for (int g = 0; g < 3; g++) begin
                s = 2*g + p;
                if (we == 4'h0)       q[s].push_back('{cyc: c + LATS[g], data: x, chk: 1'b1});
                else if (MODES[g] == 0) q[s].push_back('{cyc: c + LATS[g], data: old, chk: known});
                else if (MODES[g] == 1) q[s].push_back('{cyc: c + LATS[g], data: mrg, chk: known || we == 4'hF});
            end
        end
    endtask

    task automatic write_mdl(input int addr, input logic [3:0] we, input logic [31:0] wd);
        logic [31:0] w;
        if (mdl.exists(addr)) begin
            w = mdl[addr];
            for (int i = 0; i < 4; i++) if (we[i]) w[8*i +: 8] = wd[8*i +: 8];
            mdl[addr] = w;
        end else if (we == 4'hF) begin
            mdl[addr] = wd;
        end
    endtask

    // One clock of stimulus; ax/bx are the hand-computed read results
    task automatic step(input bit r,
                        input bit ae, input logic [3:0] awe, input int aa, input logic [31:0] ad, input logic [31:0] ax,
                        input bit be, input logic [3:0] bwe, input int ba, input logic [31:0] bd, input logic [31:0] bx);
        int c;
        @(negedge clk);
        rst = r;
        a_en = ae; a_we = awe; a_addr = 10'(aa); a_wdata = ad;
        b_en = be; b_we = bwe; b_addr = 10'(ba); b_wdata = bd;
        c = cyc;
        if (r) begin
            for (int s = 0; s < 6; s++) begin
                while (q[s].size() > 0 && q[s][$].cyc > c) void'(q[s].pop_back());
                pq[s].push_back('{cyc: c + 1, data: 32'h0, chk: 1'b1});
            end
        end else begin
            push_port(0, c, ae, awe, aa, ad, ax);
            push_port(1, c, be, bwe, ba, bd, bx);
            if (ae && be && awe != 4'h0 && bwe != 4'h0 && aa == ba)
                for (int g = 0; g < 3; g++) cq[g].push_back(c + 1);
            if (be && bwe != 4'h0) write_mdl(ba, bwe, bd);
            if (ae && awe != 4'h0) write_mdl(aa, awe, ad);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b0, 4'h0, 0, 32'h0, 32'h0);
    endtask

    // Scoreboard monitor: pops expectations as outputs appear, then reports
    always @(negedge clk) begin : monitor
        exp_t e;
        for (int s = 0; s < 6; s++) begin
            while (q[s].size() > 0 && q[s][0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL rvalid_missing stream %0d: got no rvalid by cycle %0d, required at cycle %0d", s, cyc, q[s][0].cyc);
                void'(q[s].pop_front());
            end
            if (rv[s]) begin
                checks++;
                if (q[s].size() == 0 || q[s][0].cyc != cyc) begin
                    errors++;
                    $display("FAIL rvalid_unexpected stream %0d: got rvalid=1 at cycle %0d, required 0", s, cyc);
                end else begin
                    e = q[s].pop_front();
                    if (e.chk) begin
                        checks++;
                        if (rd[s] !== e.data) begin
                            errors++;
                            $display("FAIL rdata stream %0d cycle %0d: got %08h, required %08h", s, cyc, rd[s], e.data);
                        end
                    end
                end
            end
            while (pq[s].size() > 0 && pq[s][0].cyc <= cyc) begin
                e = pq[s].pop_front();
                if (e.cyc == cyc) begin
                    checks++;
                    if (rd[s] !== e.data) begin
                        errors++;
                        $display("FAIL rdata_hold stream %0d cycle %0d: got %08h, required %08h", s, cyc, rd[s], e.data);
                    end
                end
            end
        end
        for (int g = 0; g < 3; g++) begin
            while (cq[g].size() > 0 && cq[g][0] < cyc) begin
                checks++; errors++;
                $display("FAIL collision_missing inst %0d: got 0, required 1 at cycle %0d", g, cq[g][0]);
                void'(cq[g].pop_front());
            end
            if (cl[g]) begin
                checks++;
                if (cq[g].size() > 0 && cq[g][0] == cyc) begin
                    void'(cq[g].pop_front());
                end else begin
                    errors++;
                    $display("FAIL collision_unexpected inst %0d cycle %0d: got 1, required 0", g, cyc);
                end
            end
        end
        if (done) begin
            for (int s = 0; s < 6; s++) begin
                checks++;
                if (q[s].size() != 0 || pq[s].size() != 0) begin
                    errors++;
                    $display("FAIL drain stream %0d: got %0d pending, required 0", s, q[s].size() + pq[s].size());
                end
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        step(1'b1, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b0, 4'h0, 0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b0, 4'h0, 0, 32'h0, 32'h0);

        // memory survives reset; a request during reset must not write
        step(1'b0, 1'b1, 4'hF, 5, 32'hDEADBEEF, 32'h0, 1'b0, 4'h0, 0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 4'hF, 5, 32'h12345678, 32'h0, 1'b0, 4'h0, 0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b1, 4'h0, 5, 32'h0, 32'hDEADBEEF);

        // byte enables
        step(1'b0, 1'b1, 4'hF, 3, 32'h11223344, 32'h0, 1'b0, 4'h0, 0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 4'h5, 3, 32'hAABBCCDD, 32'h0, 1'b0, 4'h0, 0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 4'h0, 3, 32'h0, 32'h11BB33DD, 1'b0, 4'h0, 0, 32'h0, 32'h0);

        // read-during-write on the same port
        step(1'b0, 1'b1, 4'hF, 7, 32'h1, 32'h0, 1'b0, 4'h0, 0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 4'hF, 7, 32'h2, 32'h0, 1'b0, 4'h0, 0, 32'h0, 32'h0);
        pq[4].push_back('{cyc: cyc + 1, data: 32'h11BB33DD, chk: 1'b1});
        step(1'b0, 1'b1, 4'h0, 7, 32'h0, 32'h2, 1'b0, 4'h0, 0, 32'h0, 32'h0);

        // same-address dual write, then dual read, then dual write elsewhere
        step(1'b0, 1'b1, 4'hC, 9, 32'hAAAA0000, 32'h0, 1'b1, 4'hF, 9, 32'h0000BBBB, 32'h0);
        step(1'b0, 1'b1, 4'h0, 9, 32'h0, 32'hAAAABBBB, 1'b1, 4'h0, 9, 32'h0, 32'hAAAABBBB);
        step(1'b0, 1'b1, 4'hF, 10, 32'h1, 32'h0, 1'b1, 4'hF, 11, 32'h2, 32'h0);

        // cross-port read while the other port writes
        step(1'b0, 1'b1, 4'hF, 2, 32'h5, 32'h0, 1'b0, 4'h0, 0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 4'hF, 2, 32'h6, 32'h0, 1'b1, 4'h0, 2, 32'h0, 32'h5);
        step(1'b0, 1'b0, 4'h0, 0, 32'h0, 32'h0, 1'b1, 4'h0, 2, 32'h0, 32'h6);

        // streaming reads, then a burst cut by reset
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 4'hF, i, 32'h100 + 32'(i), 32'h0, 1'b0, 4'h0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 4'h0, i, 32'h0, 32'h100 + 32'(i), 1'b0, 4'h0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 4'h0, i, 32'h0, 32'h100 + 32'(i), 1'b0, 4'h0, 0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 4'h0, 4, 32'h0, 32'h0, 1'b0, 4'h0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) idle();
        done = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test by time %0t, required earlier", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dp_ram_be.md
Name: dp_ram_be

Overview:
True dual-port synchronous RAM with per-byte write enables, a selectable read-during-write mode and a configurable read pipeline depth (1 or 2 cycles). Each port has a read-valid strobe, and the block flags same-address write collisions between ports. It serves as the generic on-chip buffer behind AXI-facing bridges and DMA engines. Both ports run on one clock.

Parameters:
data_width, 32, word width in bits; must be a multiple of byte_width
addr_width, 10, address bits; depth = 2**addr_width words
byte_width, 8, bits per write-enable lane; nb = data_width/byte_width
rd_latency, 1, cycles from accepted request to rdata valid; legal values 1 or 2
write_mode, 0, read-during-write on the same port: 0 read-first, 1 write-first, 2 no-change

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
a_en  in  1  port A request strobe
a_we  in  nb  port A byte write enables; all-zero = read
a_addr  in  addr_width  port A word address
a_wdata  in  data_width  port A write data
a_rdata  out  data_width  port A read data
a_rvalid  out  1  port A read data valid
b_en  in  1  port B request strobe
b_we  in  nb  port B byte write enables; all-zero = read
b_addr  in  addr_width  port B word address
b_wdata  in  data_width  port B write data
b_rdata  out  data_width  port B read data
b_rvalid  out  1  port B read data valid
collision  out  1  same-address dual-write flag

Behaviour:
- Reset (rst=1 at a clock edge): a_rdata, b_rdata, all pipeline stages, a_rvalid, b_rvalid and collision go to 0. Memory contents are not cleared. Requests presented during reset are ignored, and no write occurs.
- Request: accepted on a clock edge with x_en=1 and rst=0. With x_en=0 there is no access, rdata holds its value and rvalid is 0.
- Byte write: for each lane i with x_we[i]=1, mem[addr][i*byte_width +: byte_width] takes the corresponding wdata lane. Other lanes keep their contents.
- Latency: rvalid pulses exactly rd_latency cycles after each accepted request, for both reads and writes, except in mode 2 writes. With rd_latency=2 the extra stage is a plain register, so back-to-back requests give back-to-back valids (full throughput). rdata holds its value when rvalid=0.
- Same-port read-during-write:
  - mode 0 returns the word as it was before the write.
  - mode 1 returns the merged new word, with unwritten lanes taken from the old data.
  - mode 2 leaves rdata unchanged and keeps rvalid at 0 for that request.
- Cross-port read of an address the other port writes in the same cycle: the reader always gets the old word, whatever write_mode is set to.
- Dual write to the same address in the same cycle: lanes enabled on both ports take port A data, and lanes enabled only on B take B data. collision is set to 1 for exactly one cycle, on the edge after the conflict. Dual reads, or a read on one port with a write on the other, never raise collision.
- Address wrap: none. Every address from 0 to 2**addr_width-1 is valid.
- Reset mid-pipeline (rd_latency=2): any in-flight valid is discarded, so no rvalid appears after reset deasserts.

Test Plan:
- Reset then read: write A addr 5 = 0xDEADBEEF, pulse rst, then read B addr 5 -> b_rvalid 1 cycle later and b_rdata = 0xDEADBEEF (memory kept). Outputs are 0 during reset.
- Byte enables: write 0x11223344 to addr 3, then A write a_we=4'b0101 with data 0xAABBCCDD -> read returns 0x11BB33DD.
- Write modes: for each of modes 0, 1, 2, addr 7 holds 0x1, then A write 0x2 to addr 7 ->
  - mode 0: a_rdata=0x1, rvalid=1
  - mode 1: a_rdata=0x2, rvalid=1
  - mode 2: a_rdata unchanged, rvalid=0
- Collision: A writes 0xAAAA0000 with we=1100 and B writes 0x0000BBBB with we=1111, both to addr 9 in the same cycle -> collision=1 for one cycle, then mem[9]=0xAAAABBBB. The same cycle with different addresses -> collision stays 0.
- Cross-port read: addr 2=0x5, A writes 0x6 to addr 2 while B reads addr 2 -> b_rdata=0x5, and the next B read returns 0x6.
- rd_latency=2 streaming: 8 back-to-back A reads of addr 0..7 -> 8 consecutive rvalid cycles starting 2 cycles after the first request, with data in order. Asserting rst in the middle of the burst -> no rvalid after reset deasserts.
